div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 integer divider serving the EX stage (DIV/DIVU); EX is initiator, this block responder.
//  EX raises start_i with operands; block iterates one quotient bit per clock and returns {remainder,quotient}
//  with ready_o. EX holds pipeline stall while start_i=1 and ready_o=0; annul_i aborts on flush.
// PARAMETERS
//  WIDTH  32  operand width; result_o is 2*WIDTH; iteration counter is clog2(WIDTH)+1 bits
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        asynchronous, active-low reset (rst==0 resets immediately)
//  signed_div_i  in   1        1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//  opdata1_i     in   WIDTH    dividend; sampled on accepting edge only
//  opdata2_i     in   WIDTH    divisor; sampled on accepting edge only
//  start_i       in   1        request; EX holds high until it has consumed ready_o
//  annul_i       in   1        abort current/pending operation (pipeline flush)
//  result_o      out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}, registered
//  ready_o       out  1        result valid, registered
// BEHAVIOUR
//  Reset (async, rst==0): state=FREE, cnt=0, work regs=0, result_o=0, ready_o=0; abandons any operation.
//  States: FREE, BYZERO, ON, END (2-bit encoding).
//  FREE: ready_o=0, result_o=0. Edge with start_i=1 & annul_i=0 accepts:
//   opdata2_i==0 -> BYZERO; else -> ON, cnt=0, latch signed_div_i and sign bits of both operands,
//   load magnitudes (two's-complement negate negative operands when signed) into work regs.
//   start_i=1 & annul_i=1 -> stay FREE.
//  BYZERO: next edge -> END, result_o=0, ready_o=1 (no trap; ISA leaves result undefined, we define 0).
//  ON: each edge with annul_i=0 and cnt<WIDTH: shift {rem,quo} left 1, trial-subtract divisor from the
//   (WIDTH+1)-bit partial remainder; non-negative -> keep difference, quotient bit=1; else restore, bit=0;
//   cnt<=cnt+1. Edge with cnt==WIDTH: apply sign fix-up, write result_o, ready_o<=1, -> END.
//   Sign fix-up (signed only): quotient negated if dividend sign != divisor sign; remainder negated if
//   dividend negative (remainder takes dividend sign). Unsigned: no fix-up.
//   -2^(W-1) / -1 signed: quotient wraps to 0x80000000, remainder 0; no overflow flag.
//  annul_i=1 in ON or BYZERO: next edge -> FREE, cnt=0, result_o=0, ready_o=0; no result produced.
//  END: result_o/ready_o held stable. Edge with start_i=0 -> FREE, ready_o=0, result_o=0.
//   start_i=1 stays END (no back-to-back restart without a start_i=0 cycle); annul_i ignored in END.
//  start_i changes and operand changes while in ON/BYZERO/END ignored (operands latched at accept).
//  Latency (accept edge = edge 0): normal: ready_o rises after edge WIDTH+1 (edge 33 for W=32);
//   divide-by-zero: ready_o rises after edge 2? no -- after edge 1 (BYZERO->END).
//  Throughput: one operation per WIDTH+3 cycles minimum (accept, WIDTH iters, fix-up, drop-start cycle).
// TESTING
//  1 DIVU 100/7: start edge 0 -> ready_o=1 first after edge 33, result_o={32'd2,32'd14}; hold 3 cycles, stable.
//  2 DIV -7/2: opdata1=0xFFFFFFF9, opdata2=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7/-2 -> q 0xFFFFFFFD, r 1.
//  3 Divide by zero: DIVU 5/0 -> ready_o=1 after edge 1, result_o=0; drop start_i -> FREE, ready_o=0 next edge.
//  4 annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises; fresh DIVU 0xFFFFFFFF/0x10
//    accepted next cycle -> q 0x0FFFFFFF, r 0xF.
//  5 Corners: DIV 0x80000000/0xFFFFFFFF -> q 0x80000000, r 0; DIVU 3/0xFFFFFFFF -> q 0, r 3.
//  6 rst driven low mid-ON (iteration 20, between edges) -> outputs 0 immediately without clock; after release
//    a new 100/7 completes correctly at edge 33.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring integer divider for the EX stage (DIV/DIVU).
// Produces one quotient bit per clock and returns {remainder, quotient}.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t             state, state_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [WIDTH-1:0]   rem, rem_d;
    logic [WIDTH-1:0]   quo, quo_d;
    logic [WIDTH-1:0]   dvs, dvs_d;
    logic               sgn, sgn_d;
    logic               neg1, neg1_d;
    logic               neg2, neg2_d;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    logic               in_neg1, in_neg2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     partial, diff;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign in_neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign in_neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign mag1    = in_neg1 ? -opdata1_i : opdata1_i;
    assign mag2    = in_neg2 ? -opdata2_i : opdata2_i;

    // Partial remainder carries one extra bit so the trial difference sign is visible.
    assign partial = {rem, quo[WIDTH-1]};
    assign diff    = partial - {1'b0, dvs};

    assign q_fix = (sgn && (neg1 ^ neg2)) ? -quo : quo;
    assign r_fix = (sgn && neg1) ? -rem : rem;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rem_d    = rem;
        quo_d    = quo;
        dvs_d    = dvs;
        sgn_d    = sgn;
        neg1_d   = neg1;
        neg2_d   = neg2;
        result_d = result_o;
        ready_d  = ready_o;
        unique case (state)
            ST_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        sgn_d   = signed_div_i;
                        neg1_d  = in_neg1;
                        neg2_d  = in_neg2;
                        rem_d   = '0;
                        quo_d   = mag1;
                        dvs_d   = mag2;
                    end
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = ST_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt == LAST) begin
                    state_d  = ST_END;
                    result_d = {r_fix, q_fix};
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = partial[WIDTH-1:0];
                        quo_d = {quo[WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d  = ST_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = ST_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            sgn      <= 1'b0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rem      <= rem_d;
            quo      <= quo_d;
            dvs      <= dvs_d;
            sgn      <= sgn_d;
            neg1     <= neg1_d;
            neg2     <= neg2_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, corner operands and asynchronous reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;

    int          lat;
    logic [63:0] res;
    int          seen;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drive a request, return first edge index (after accept) with ready high.
    task automatic run_op(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output int l,
                          output logic [63:0] r);
        signed_div = sgn;
        op1 = a;
        op2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        op1 = ~a;
        op2 = ~b;
        signed_div = ~sgn;
        l = -1;
        r = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                l = i;
                r = result;
                break;
            end
        end
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        chk({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        signed_div = 1'b0;
        op1 = '0;
        op2 = '0;
        start = 1'b0;
        annul = 1'b0;
        #12;
        chk("rst_rdy", 64'(ready), 64'd0);
        chk("rst_res", result, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: DIVU 100/7, held result, annul ignored in END
        run_op(1'b0, 32'd100, 32'd7, lat, res);
        chk("t1_lat", 64'(lat), 64'd33);
        chk("t1_res", res, {32'd2, 32'd14});
        for (int i = 0; i < 3; i++) begin
            annul = (i == 1);
            @(posedge clk);
            #1;
            chk("t1_hold_rdy", 64'(ready), 64'd1);
            chk("t1_hold_res", result, {32'd2, 32'd14});
        end
        annul = 1'b0;
        drop_start("t1");

        // 2: signed with mixed signs
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res);
        chk("t2a_lat", 64'(lat), 64'd33);
        chk("t2a_res", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drop_start("t2a");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, res);
        chk("t2b_res", res, {32'd1, 32'hFFFF_FFFD});
        drop_start("t2b");

        // 3: divide by zero
        run_op(1'b0, 32'd5, 32'd0, lat, res);
        chk("t3_lat", 64'(lat), 64'd1);
        chk("t3_res", res, 64'd0);
        drop_start("t3");

        // 4: annul mid-iteration, then fresh operation
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("t4_annul_rdy", 64'(ready), 64'd0);
        chk("t4_annul_res", result, 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, lat, res);
        chk("t4_lat", 64'(lat), 64'd33);
        chk("t4_res", res, {32'hF, 32'h0FFF_FFFF});
        drop_start("t4");

        // start with annul in FREE is not accepted
        signed_div = 1'b0;
        op1 = 32'd9;
        op2 = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        annul = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        chk("free_annul_seen", 64'(seen), 64'd0);

        // 5: corners
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        chk("t5a_res", res, {32'd0, 32'h8000_0000});
        drop_start("t5a");
        run_op(1'b0, 32'd3, 32'hFFFF_FFFF, lat, res);
        chk("t5b_res", res, {32'd3, 32'd0});
        drop_start("t5b");

        // 6a: async reset while a result is held
        run_op(1'b0, 32'd100, 32'd7, lat, res);
        chk("t6a_pre_rdy", 64'(ready), 64'd1);
        #2;
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("t6a_rst_rdy", 64'(ready), 64'd0);
        chk("t6a_rst_res", result, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 6b: async reset mid-iteration, then a new operation
        signed_div = 1'b0;
        op1 = 32'd50;
        op2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("t6b_rst_rdy", 64'(ready), 64'd0);
        chk("t6b_rst_res", result, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6b_idle_rdy", 64'(ready), 64'd0);
        run_op(1'b0, 32'd100, 32'd7, lat, res);
        chk("t6b_lat", 64'(lat), 64'd33);
        chk("t6b_res", res, {32'd2, 32'd14});
        drop_start("t6b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
